// File: rtl/sram_bus_ctrl.sv
`timescale 1ns/1ps
// Host-side controller for a 256x8 asynchronous SRAM: turns valid/ready requests
// into registered cs/wr/rd strobe sequences with parameterised setup/pulse/hold.
module sram_bus_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       sram_cs,
  output logic       sram_wr,
  output logic       sram_rd,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_din,
  input  logic [7:0] sram_dout
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255 || PULSE_CYC < 1 || PULSE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_param_check
    $error("sram_bus_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must be in 1..255");
  end

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic       cnt_last_s;
  logic       accept_s;
  logic       capture_s;
  logic       we_r;
  logic       req_ready_r;
  logic       rsp_valid_r;
  logic [7:0] rsp_rdata_r;
  logic       sram_cs_r;
  logic       sram_wr_r;
  logic       sram_rd_r;
  logic [7:0] sram_addr_r;
  logic [7:0] sram_din_r;

  assign cnt_last_s = (cnt_r == 8'd1);

  // Next-state and shared phase counter; one counter is reloaded at each phase change.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
          cnt_s    = SETUP_LD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_last_s) begin
          state_s = ST_STROBE;
          cnt_s   = PULSE_LD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_last_s) begin
          state_s   = ST_HOLD;
          cnt_s     = HOLD_LD;
          capture_s = !we_r;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_last_s) begin
          state_s = we_r ? ST_IDLE : ST_RESP;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Outputs are decoded from the next state so every pin changes exactly on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      sram_cs_r   <= 1'b0;
      sram_wr_r   <= 1'b1;
      sram_rd_r   <= 1'b1;
      sram_addr_r <= 8'h00;
      sram_din_r  <= 8'h00;
    end else begin
      req_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_RESP);
      sram_cs_r   <= (state_s == ST_SETUP) || (state_s == ST_STROBE) || (state_s == ST_HOLD);
      sram_wr_r   <= !((state_s == ST_STROBE) && we_r);
      sram_rd_r   <= !((state_s == ST_STROBE) && !we_r);
      if (accept_s) begin
        we_r        <= req_we;
        sram_addr_r <= req_addr;
        if (req_we) begin
          sram_din_r <= req_wdata;
        end
      end
      // Sample while rd is still low, on the edge that ends the pulse.
      if (capture_s) begin
        rsp_rdata_r <= sram_dout;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign sram_cs   = sram_cs_r;
  assign sram_wr   = sram_wr_r;
  assign sram_rd   = sram_rd_r;
  assign sram_addr = sram_addr_r;
  assign sram_din  = sram_din_r;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sram_bus_ctrl: behavioural SRAM, reference memory and
// a read-data scoreboard queue; inputs driven and outputs sampled on negedges.
module tb_sram_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_we, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic       sram_cs, sram_wr, sram_rd;
  logic [7:0] sram_addr, sram_din, sram_dout;

  logic       req_valid2, req_we2, req_ready2, rsp_valid2, rsp_ready2;
  logic [7:0] req_addr2, req_wdata2, rsp_rdata2;
  logic       sram_cs2, sram_wr2, sram_rd2;
  logic [7:0] sram_addr2, sram_din2, sram_dout2;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic to_flag = 1'b0;
  logic mon_en = 1'b0;
  int excl_viol = 0;
  int cs_viol = 0;
  int rdy_viol = 0;

  sram_bus_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  sram_bus_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
    .sram_cs(sram_cs2), .sram_wr(sram_wr2), .sram_rd(sram_rd2),
    .sram_addr(sram_addr2), .sram_din(sram_din2), .sram_dout(sram_dout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous SRAM: writes on the rising edge of wr, drives data while rd is low.
  always @(posedge sram_wr) begin
    if (sram_cs === 1'b1) mem[sram_addr] <= sram_din;
  end
  assign sram_dout  = (sram_cs && !sram_rd) ? mem[sram_addr] : 8'hEE;
  assign sram_dout2 = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sram_wr === 1'b0 && sram_rd === 1'b0) excl_viol <= excl_viol + 1;
      if (sram_cs === 1'b0 && (sram_wr === 1'b0 || sram_rd === 1'b0)) cs_viol <= cs_viol + 1;
      if (req_ready === 1'b1 && (sram_cs === 1'b1 || rsp_valid === 1'b1)) rdy_viol <= rdy_viol + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles expected completion", cyc);
    $fatal(1, "watchdog");
  end

  // Present a request at a negedge, wait for acceptance, return at the negedge of cycle 1.
  task automatic issue_req(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) to_flag = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, output int lat);
    int n;
    ref_mem[a] = d;
    issue_req(1'b1, a, d);
    n = 1;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    lat = (n < 200) ? n : -1;
    if (n >= 200) to_flag = 1'b1;
  endtask

  task automatic do_read(input logic [7:0] a, input logic rnd, output logic [7:0] data,
                         output int lat, output logic rdy_next);
    int n;
    issue_req(1'b0, a, 8'h00);
    n = 1; lat = -1;
    rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      if (rsp_valid === 1'b1 && lat < 0) lat = n;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) break;
      if (n >= 300) begin to_flag = 1'b1; lat = -1; break; end
      @(negedge clk); n++;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    end
    data = rsp_rdata;
    @(negedge clk);
    rdy_next = req_ready;
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
    n_checks++; if ({sram_cs, sram_wr, sram_rd} !== 3'b011) begin n_fail++; $display("FAIL reset_strobes: got cs/wr/rd=%b expected 011", {sram_cs, sram_wr, sram_rd}); end
    n_checks++; if ({sram_addr, sram_din} !== 16'h0000) begin n_fail++; $display("FAIL reset_addr_din: got %h expected 0000", {sram_addr, sram_din}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] d; logic rn;
    do_write(8'h3C, 8'hA5, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL write_latency: got %0d expected 5", lat); end
    exp_q.push_back(ref_mem[8'h3C]);
    do_read(8'h3C, 1'b0, d, lat, rn);
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL read_data_3c: got %h expected a5", d); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL read_latency: got %0d expected 5", lat); end
    n_checks++; if (rn !== 1'b1) begin n_fail++; $display("FAIL read_ready_return: got %b expected 1", rn); end
  endtask

  task automatic test_strobe_widths();
    int n, cs_cnt, wr_cnt, rd_cnt, cs_first, wr_first;
    req_we2 = 1'b1; req_addr2 = 8'hFF; req_wdata2 = 8'h3C; req_valid2 = 1'b1;
    n = 0;
    while (req_ready2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid2 = 1'b0;
    cs_cnt = 0; wr_cnt = 0; rd_cnt = 0; cs_first = -1; wr_first = -1;
    for (int i = 0; i < 20; i++) begin
      if (sram_cs2 === 1'b1) begin cs_cnt++; if (cs_first < 0) cs_first = i; end
      if (sram_wr2 === 1'b0) begin wr_cnt++; if (wr_first < 0) wr_first = i; end
      if (sram_rd2 === 1'b0) rd_cnt++;
      @(negedge clk);
    end
    n_checks++; if (n >= 200) begin n_fail++; $display("FAIL widths_accept: got timeout expected ready"); end
    n_checks++; if (cs_cnt !== 6) begin n_fail++; $display("FAIL widths_cs: got %0d cycles expected 6", cs_cnt); end
    n_checks++; if (wr_cnt !== 3) begin n_fail++; $display("FAIL widths_wr: got %0d cycles expected 3", wr_cnt); end
    n_checks++; if (cs_first !== 0) begin n_fail++; $display("FAIL widths_cs_start: got %0d expected 0", cs_first); end
    n_checks++; if (wr_first - cs_first !== 2) begin n_fail++; $display("FAIL widths_wr_offset: got %0d expected 2", wr_first - cs_first); end
    n_checks++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL widths_rd: got %0d expected 0", rd_cnt); end
    n_checks++; if ({sram_addr2, sram_din2} !== 16'hFF3C) begin n_fail++; $display("FAIL widths_idle_addr_din: got %h expected ff3c", {sram_addr2, sram_din2}); end
    n_checks++; if ({rsp_valid2, rsp_rdata2} !== 9'h000) begin n_fail++; $display("FAIL widths_no_response: got %h expected 000", {rsp_valid2, rsp_rdata2}); end
  endtask

  task automatic test_back_to_back();
    int n, lat; int acc [4]; logic [7:0] d; logic rn;
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 8'(i); req_wdata = 8'h10 + 8'(i);
      ref_mem[8'(i)] = 8'h10 + 8'(i);
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) to_flag = 1'b1;
      acc[i] = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (acc[i] - acc[i-1] !== 5) begin n_fail++; $display("FAIL b2b_period_%0d: got %0d expected 5", i, acc[i] - acc[i-1]); end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[8'(i)]);
    for (int i = 0; i < 4; i++) begin
      do_read(8'(i), 1'b0, d, lat, rn);
      n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_read_%0d: got %h expected %h", i, d, 8'h10 + 8'(i)); end
    end
    n_checks++; if (rdy_viol !== 0) begin n_fail++; $display("FAIL b2b_ready_outside_idle: got %0d expected 0", rdy_viol); end
  endtask

  task automatic test_backpressure();
    int n; logic [7:0] e;
    exp_q.push_back(ref_mem[8'h02]);
    rsp_ready = 1'b0;
    issue_req(1'b0, 8'h02, 8'h00);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b expected 1", i, rsp_valid); end
      n_checks++; if (rsp_rdata !== e) begin n_fail++; $display("FAIL bp_data_%0d: got %h expected %h", i, rsp_rdata, e); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d: got %b expected 0", i, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int n, lat; logic [7:0] d; logic rn;
    issue_req(1'b1, 8'h50, 8'h77);
    n = 0;
    while (sram_wr !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) to_flag = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({sram_cs, sram_wr, sram_rd} !== 3'b011) begin n_fail++; $display("FAIL midrst_strobes: got cs/wr/rd=%b expected 011", {sram_cs, sram_wr, sram_rd}); end
    n_checks++; if ({rsp_valid, req_ready} !== 2'b00) begin n_fail++; $display("FAIL midrst_valid_ready: got %b expected 00", {rsp_valid, req_ready}); end
    rst_n = 1'b1;
    @(negedge clk);
    do_write(8'h60, 8'h5A, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_write_latency: got %0d expected 5", lat); end
    exp_q.push_back(ref_mem[8'h60]);
    do_read(8'h60, 1'b0, d, lat, rn);
    n_checks++; if (d !== exp_q.pop_front()) begin n_fail++; $display("FAIL midrst_read_data: got %h expected 5a", d); end
    // A response pending at reset must be dropped.
    rsp_ready = 1'b0;
    issue_req(1'b0, 8'h60, 8'h00);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL midrst_rsp_discard: got valid/ready=%b expected 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_strobe_exclusivity();
    int lat; logic [7:0] d, e, a; logic rn; int nr;
    for (int i = 0; i < 16; i++) do_write(8'(i), 8'($urandom_range(0, 255)), lat);
    nr = 0;
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, 8'($urandom_range(0, 255)), lat);
      end else begin
        exp_q.push_back(ref_mem[a]);
        do_read(a, 1'b1, d, lat, rn);
        e = exp_q.pop_front();
        nr++;
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand_read_%0d: addr %h got %h expected %h", k, a, d, e); end
      end
    end
    n_checks++; if (nr == 0) begin n_fail++; $display("FAIL rand_read_count: got 0 expected nonzero"); end
    n_checks++; if (excl_viol !== 0) begin n_fail++; $display("FAIL excl_both_low: got %0d cycles expected 0", excl_viol); end
    n_checks++; if (cs_viol !== 0) begin n_fail++; $display("FAIL excl_strobe_without_cs: got %0d cycles expected 0", cs_viol); end
    n_checks++; if (rdy_viol !== 0) begin n_fail++; $display("FAIL excl_ready_outside_idle: got %0d cycles expected 0", rdy_viol); end
    n_checks++; if (to_flag !== 1'b0) begin n_fail++; $display("FAIL handshake_timeout: got %b expected 0", to_flag); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 8'h00; rsp_ready2 = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_strobe_widths();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_write();
    test_strobe_exclusivity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_ctrl.md
# sram_bus_ctrl

Clocked host-side controller that sits directly upstream of the 256×8 asynchronous SRAM. It converts single-beat valid/ready read and write requests into the SRAM's strobe sequence (`cs`, active-low `wr`/`rd`). It returns read data through a valid/ready response channel. All SRAM-side outputs are registered, so strobes and address are glitch-free and their setup, pulse and hold widths are set by parameters.

## Interface
- `SETUP_CYC`, default 1: cycles that `cs` and address (and write data) are stable before the strobe falls. Legal range 1..255.
- `PULSE_CYC`, default 2: cycles that the strobe (`sram_wr` or `sram_rd`) is held low. Legal range 1..255.
- `HOLD_CYC`, default 1: cycles after the strobe rises during which `cs`, address and data are still held. Legal range 1..255.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  SRAM address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  host accepts the read data.
- `rsp_rdata`  out  8  read data.
- `sram_cs`  out  1  chip select, active-high.
- `sram_wr`  out  1  write strobe, active-low. The SRAM writes on its rising edge.
- `sram_rd`  out  1  read strobe, active-low. The SRAM drives its output while it is low.
- `sram_addr`  out  8  SRAM address.
- `sram_din`  out  8  data to the SRAM.
- `sram_dout`  in  8  data from the SRAM. Valid only while `sram_cs`=1 and `sram_rd`=0.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD, RESP. One 8-bit down-counter is shared by SETUP, STROBE and HOLD.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, capture `req_we`/`req_addr`/`req_wdata`, load the counter with SETUP_CYC, and go to SETUP.
- **SETUP:**
  - `sram_cs`=1, `sram_addr` = captured address, `sram_din` = captured data (writes only), `sram_wr`=`sram_rd`=1.
  - When the counter expires, go to STROBE.
- **STROBE:**
  - The strobe selected by `req_we` is low and the other stays high. `sram_wr` and `sram_rd` are never both low.
  - Read: register `sram_dout` into `rsp_rdata` on the last STROBE cycle, while `sram_rd` is still low.
- **HOLD:**
  - The strobe returns high and `cs`/addr/data stay unchanged. For a write, the SRAM captures data at this `sram_wr` rising edge.
  - When the counter expires: a write goes to IDLE with `sram_cs`=0; a read goes to RESP with `sram_cs`=0.
- **RESP:**
  - `rsp_valid`=1 and `rsp_rdata` stable until `rsp_ready`; then go to IDLE.
  - `rsp_valid` is held indefinitely under backpressure.
- **Writes:** produce no response.
- **Request ordering:** one transaction at a time, with no overlap or queuing. `req_ready`=0 in every non-IDLE state, and `req_valid` is ignored there.
- **Address/data while idle:** `sram_addr`/`sram_din` keep their last values when idle. Only `cs` and the strobes return to idle levels.
- **Illegal parameters:** any parameter of 0 is illegal and flagged by an elaboration-time check. Behaviour is not defined.

## Timing
- **Reset values:**
  - Outputs: `req_ready`=0 during reset and 1 on the first cycle after release, `rsp_valid`=0, `rsp_rdata`=8'h00, `sram_cs`=0, `sram_wr`=1, `sram_rd`=1, `sram_addr`=8'h00, `sram_din`=8'h00.
  - State: IDLE.
- **Cycle numbering:** with request acceptance at edge 0, SETUP occupies cycles 1..S, STROBE S+1..S+P, and HOLD S+P+1..S+P+H.
- **Write completion:** `req_ready` is high again at cycle S+P+H+1, giving a back-to-back write period of S+P+H+1 cycles.
- **Read completion:**
  - `rsp_valid` rises at cycle S+P+H+1.
  - If `rsp_ready` is already high, `req_ready` returns at cycle S+P+H+2.
- **Strobe edges:** every SRAM strobe edge coincides with a clock edge. Address and data never change in the same cycle as a strobe edge.
- **Reset mid-operation:**
  - The next clock edge forces all outputs to their reset values and the state to IDLE.
  - A write interrupted in STROBE drops `cs` on the same edge that `wr` rises, so the contents of that address are undefined.
  - A pending response is discarded.
- **rsp_ready outside RESP:** ignored.

## Test plan
- **Basic write then read:** reset, write 8'hA5 to 8'h3C, then read 8'h3C → `rsp_valid` with `rsp_rdata`=8'hA5. The read response arrives at cycle S+P+H+1 after acceptance (cycle 5 with defaults).
- **Strobe widths:** set SETUP=2, PULSE=3, HOLD=1 and write address 8'hFF → `sram_cs` high for exactly 6 cycles, and `sram_wr` low for exactly 3 cycles, starting 2 cycles after `cs` rises.
- **Back-to-back requests:** hold `req_valid`=1 for 4 writes (addr 0..3, data 8'h10..8'h13), then read all four → reads return 8'h10..8'h13 in order, and `req_ready` is never high outside IDLE.
- **Response backpressure:** read with `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_rdata` stay stable, and `req_ready`=0 throughout. Asserting `rsp_ready` for one cycle → IDLE on the next cycle.
- **Reset mid-write:** assert `rst_n`=0 during STROBE of a write → on the next edge `sram_cs`=0, `sram_wr`=1, `sram_rd`=1 and `rsp_valid`=0. A subsequent write/read to another address works normally.
- **Strobe exclusivity:** over a random mix of 1000 reads and writes with random `rsp_ready`, check every cycle that `sram_wr` and `sram_rd` are never both 0, and that neither strobe is low while `sram_cs`=0.
